// File: rtl/if_fetch_unit_if.sv
// ============================================================================
// if_fetch_unit_if : pipeline-control and instruction-memory signals of the
//                    IF stage; master = fetch unit, slave = environment
// Revision 1.0
// ============================================================================
`default_nettype none

interface if_fetch_unit_if;
   logic        stall;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [15:0] imem_rdata;
   logic [15:0] if_pc;
   logic [15:0] if_instr;
   logic        if_valid;

   modport master (
      input  stall, redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata,
      output imem_req, imem_addr, if_pc, if_instr, if_valid
   );

   modport slave (
      output stall, redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata,
      input  imem_req, imem_addr, if_pc, if_instr, if_valid
   );
endinterface

`default_nettype wire

// File: rtl/if_fetch_unit.sv
// ============================================================================
// if_fetch_unit : IF stage with fetch PC, single-outstanding imem reader and
//                 prefetch FIFO presenting {pc, instr} to IF/ID
// Revision 1.0
// ============================================================================
`default_nettype none

module if_fetch_unit #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter int          DEPTH    = 2
) (
   input  wire logic       clk,
   input  wire logic       rst,
   if_fetch_unit_if.master io_bus
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] c_DEPTH_CNT = CW'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DROP = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_state_next;
   logic [15:0]   r_fetch_pc;
   logic [15:0]   r_inflight_pc;
   logic [15:0]   r_fifo_pc    [DEPTH];
   logic [15:0]   r_fifo_instr [DEPTH];
   logic [AW-1:0] r_rd_ptr;
   logic [AW-1:0] r_wr_ptr;
   logic [CW-1:0] r_count;

   logic          w_valid;
   logic          w_rvalid_now;
   logic          w_push;
   logic          w_pop;
   logic [CW-1:0] w_count_next;
   logic          w_req_core;
   logic          w_fire;

   assign w_valid      = (r_count != '0);
   assign w_rvalid_now = io_bus.imem_rvalid && (r_state != S_IDLE);
   assign w_push       = (r_state == S_WAIT) && io_bus.imem_rvalid && !io_bus.redirect;
   assign w_pop        = w_valid && !io_bus.stall;
   assign w_count_next = r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};

   // Issue only when the slot the returning word would take is guaranteed free.
   assign w_req_core = !io_bus.redirect
                    && ((r_state == S_IDLE) || w_rvalid_now)
                    && (w_count_next < c_DEPTH_CNT);
   assign w_fire     = w_req_core && io_bus.imem_gnt;

   assign io_bus.imem_req  = w_req_core && !rst;
   assign io_bus.imem_addr = r_fetch_pc;
   assign io_bus.if_valid  = w_valid;
   assign io_bus.if_pc     = w_valid ? r_fifo_pc[r_rd_ptr]    : 16'h0000;
   assign io_bus.if_instr  = w_valid ? r_fifo_instr[r_rd_ptr] : 16'h0000;

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_fire) w_state_next = S_WAIT;
         end
         S_WAIT: begin
            if (io_bus.imem_rvalid)   w_state_next = w_fire ? S_WAIT : S_IDLE;
            else if (io_bus.redirect) w_state_next = S_DROP;
         end
         S_DROP: begin
            if (io_bus.imem_rvalid) w_state_next = w_fire ? S_WAIT : S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_next;
   end

   // Redirect wins over everything: flush the queue and retarget the PC.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fetch_pc    <= RESET_PC;
         r_inflight_pc <= 16'h0000;
         r_rd_ptr      <= '0;
         r_wr_ptr      <= '0;
         r_count       <= '0;
      end else if (io_bus.redirect) begin
         r_fetch_pc <= io_bus.redirect_pc;
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_count    <= '0;
      end else begin
         if (w_fire) begin
            r_inflight_pc <= r_fetch_pc;
            r_fetch_pc    <= r_fetch_pc + 16'h0001;
         end
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= w_count_next;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_pc[r_wr_ptr]    <= r_inflight_pc;
         r_fifo_instr[r_wr_ptr] <= io_bus.imem_rdata;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
// ============================================================================
// tb_if_fetch_unit : directed bench with memory model and {pc,instr} scoreboard
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_if_fetch_unit;

   logic clk = 1'b0;
   logic rst = 1'b1;

   if_fetch_unit_if bus();

   if_fetch_unit #(.RESET_PC(16'h0000), .DEPTH(2)) u_dut (
      .clk    (clk),
      .rst    (rst),
      .io_bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] pc;
      logic [15:0] instr;
   } ent_t;

   ent_t        sb[$];
   int          n_vec = 0;
   int          n_err = 0;
   logic        gnt_en;
   int          lat;
   logic        mem_pend;
   int          mem_wait;
   logic [15:0] mem_addr;
   logic        beef;
   logic [15:0] exp_pc;
   logic        s_req, s_valid, s_fire;
   logic [15:0] s_addr, s_pc, s_instr;
   logic [15:0] hold_pc;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock: drive memory response, sample mid-cycle, update models.
   task automatic cycle();
      logic r;
      logic fire;
      r = mem_pend && (mem_wait == 0);
      bus.imem_gnt    = gnt_en;
      bus.imem_rvalid = r;
      bus.imem_rdata  = r ? (beef ? 16'hBEEF : 16'h1000 + mem_addr) : 16'h0000;
      @(negedge clk);
      s_req   = bus.imem_req;
      s_addr  = bus.imem_addr;
      s_valid = bus.if_valid;
      s_pc    = bus.if_pc;
      s_instr = bus.if_instr;
      fire    = bus.imem_req && bus.imem_gnt;
      s_fire  = fire;
      if (rst) chk("rst_req", {15'b0, s_req}, 16'h0000);
      if (s_req) chk("imem_addr", s_addr, exp_pc);
      if (s_valid) begin
         if (sb.size() == 0) chk("valid_without_expected", {15'b0, s_valid}, 16'h0000);
         else begin
            chk("if_pc", s_pc, sb[0].pc);
            chk("if_instr", s_instr, sb[0].instr);
         end
      end else begin
         chk("empty_pc", s_pc, 16'h0000);
         chk("empty_instr", s_instr, 16'h0000);
      end
      if (fire) chk("one_outstanding", {15'b0, mem_pend && !r}, 16'h0000);
      if (rst || bus.redirect) sb.delete();
      else if (s_valid && !bus.stall && sb.size() > 0) void'(sb.pop_front());
      if (rst) exp_pc = 16'h0000;
      else if (bus.redirect) exp_pc = bus.redirect_pc;
      else if (fire) begin
         sb.push_back('{pc: exp_pc, instr: 16'h1000 + exp_pc});
         exp_pc = exp_pc + 16'h0001;
      end
      if (r) begin
         mem_pend = 1'b0;
         beef     = 1'b0;
      end else if (mem_pend) mem_wait--;
      if (fire) begin
         mem_pend = 1'b1;
         mem_addr = s_addr;
         mem_wait = lat - 1;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.stall       = 1'b0;
      bus.redirect    = 1'b0;
      bus.redirect_pc = 16'h0000;
      bus.imem_gnt    = 1'b0;
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = 16'h0000;
      gnt_en   = 1'b1;
      lat      = 1;
      mem_pend = 1'b0;
      mem_wait = 0;
      mem_addr = 16'h0000;
      beef     = 1'b0;
      exp_pc   = 16'h0000;
      s_fire   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_valid", {15'b0, bus.if_valid}, 16'h0000);
      chk("reset_pc", bus.if_pc, 16'h0000);
      chk("reset_instr", bus.if_instr, 16'h0000);
      chk("reset_req", {15'b0, bus.imem_req}, 16'h0000);
      rst = 1'b0;

      // Zero-wait stream: one instruction per cycle.
      cycle();
      chk("t1_req", {15'b0, s_req}, 16'h0001);
      chk("t1_addr0", s_addr, 16'h0000);
      cycle();
      chk("t1_addr1", s_addr, 16'h0001);
      cycle();
      chk("t1_pc0", s_pc, 16'h0000);
      chk("t1_instr0", s_instr, 16'h1000);
      cycle();
      chk("t1_pc1", s_pc, 16'h0001);
      chk("t1_instr1", s_instr, 16'h1001);
      cycle();
      chk("t1_pc2", s_pc, 16'h0002);
      chk("t1_instr2", s_instr, 16'h1002);
      repeat (4) cycle();

      // Stall: FIFO fills, requests stop, head frozen.
      bus.stall = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk("t2_req_off", {15'b0, s_req}, 16'h0000);
         chk("t2_valid", {15'b0, s_valid}, 16'h0001);
      end
      bus.stall = 1'b0;
      repeat (6) cycle();

      // Grant withheld: request and address held.
      hold_pc = exp_pc;
      gnt_en  = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("t3_req_held", {15'b0, s_req}, 16'h0001);
         chk("t3_addr_held", s_addr, hold_pc);
      end
      gnt_en = 1'b1;
      repeat (4) cycle();

      // Redirect while a read is outstanding; its data must be dropped.
      lat = 2;
      cycle();
      for (int i = 0; i < 10 && !s_fire; i++) cycle();
      chk("t4_fire_seen", {15'b0, s_fire}, 16'h0001);
      bus.redirect    = 1'b1;
      bus.redirect_pc = 16'h0040;
      beef            = 1'b1;
      cycle();
      chk("t4_redirect_req", {15'b0, s_req}, 16'h0000);
      bus.redirect = 1'b0;
      cycle();
      chk("t4_req", {15'b0, s_req}, 16'h0001);
      chk("t4_addr", s_addr, 16'h0040);
      for (int i = 0; i < 10 && !s_valid; i++) begin
         cycle();
         chk("t4_no_beef", {15'b0, s_instr == 16'hBEEF}, 16'h0000);
      end
      chk("t4_first_pc", s_pc, 16'h0040);
      lat = 1;
      repeat (3) cycle();

      // Full FIFO, stall and redirect together.
      bus.stall = 1'b1;
      repeat (6) cycle();
      chk("t5_full_req", {15'b0, s_req}, 16'h0000);
      chk("t5_full_valid", {15'b0, s_valid}, 16'h0001);
      bus.redirect    = 1'b1;
      bus.redirect_pc = 16'h0080;
      cycle();
      bus.redirect = 1'b0;
      bus.stall    = 1'b0;
      cycle();
      chk("t5_valid", {15'b0, s_valid}, 16'h0000);
      chk("t5_pc", s_pc, 16'h0000);
      chk("t5_instr", s_instr, 16'h0000);
      chk("t5_req", {15'b0, s_req}, 16'h0001);
      chk("t5_addr", s_addr, 16'h0080);
      repeat (4) cycle();

      // Reset in the middle of an outstanding read.
      lat = 2;
      cycle();
      for (int i = 0; i < 10 && !s_fire; i++) cycle();
      chk("t6_fire_seen", {15'b0, s_fire}, 16'h0001);
      rst = 1'b1;
      #1;
      chk("t6_async_valid", {15'b0, bus.if_valid}, 16'h0000);
      chk("t6_async_pc", bus.if_pc, 16'h0000);
      chk("t6_async_instr", bus.if_instr, 16'h0000);
      chk("t6_async_req", {15'b0, bus.imem_req}, 16'h0000);
      cycle();
      cycle();
      chk("t6_late_rvalid_valid", {15'b0, s_valid}, 16'h0000);
      rst = 1'b0;
      lat = 1;
      cycle();
      chk("t6_req", {15'b0, s_req}, 16'h0001);
      chk("t6_addr", s_addr, 16'h0000);
      repeat (4) cycle();

      // PC wrap.
      bus.redirect    = 1'b1;
      bus.redirect_pc = 16'hFFFF;
      cycle();
      bus.redirect = 1'b0;
      cycle();
      chk("t7_req", {15'b0, s_req}, 16'h0001);
      chk("t7_addr_ffff", s_addr, 16'hFFFF);
      cycle();
      chk("t7_addr_wrap", s_addr, 16'h0000);
      repeat (5) cycle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
